// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the hazard/MEM-stage sources and the pipeline stall controller.
// The master side drives the hazard, branch and SRAM status signals; the slave side is the controller.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exe_freeze;
  logic             memwb_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout_err;

  modport master (
    output hazard_detected, branch_taken, mem_req, sram_ready,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exe_freeze, memwb_bubble,
    input  stall_cycles, flush_count, mem_timeout_err
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, sram_ready,
    output pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exe_freeze, memwb_bubble,
    output stall_cycles, flush_count, mem_timeout_err
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: Mealy freeze/flush/bubble controls with
// priority memory wait > branch flush > hazard stall, plus saturating counters and a sticky SRAM timeout flag.
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              err_q, err_d;

  logic pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exe_freeze, memwb_bubble;
  logic mem_wait;

  always_comb begin
    state_d      = state_q;
    mem_wait     = 1'b0;
    pc_freeze    = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exe_freeze   = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (bus.mem_req && !bus.sram_ready) begin
            mem_wait = 1'b1;
            state_d  = MEM_WAIT;
          end else if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (bus.hazard_detected) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          // The release cycle lets the whole pipeline advance with no control asserted.
          if (bus.sram_ready) begin
            state_d = RUN;
          end else begin
            mem_wait = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
      if (mem_wait) begin
        pc_freeze    = 1'b1;
        ifid_freeze  = 1'b1;
        exe_freeze   = 1'b1;
        memwb_bubble = 1'b1;
      end
    end
  end

  // The RUN cycle that first sees the unready access is itself wait cycle 1.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_q == RUN && bus.mem_req && !bus.sram_ready) begin
      wait_cnt_d = WAIT_W'(1);
    end else if (state_q == MEM_WAIT && !bus.sram_ready && wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    if (mem_wait && wait_cnt_d == WAIT_MAX) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_freeze && stall_q != CNT_MAX) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (ifid_flush && flush_q != CNT_MAX) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
    end
  end

  assign bus.pc_freeze       = pc_freeze;
  assign bus.ifid_freeze     = ifid_freeze;
  assign bus.ifid_flush      = ifid_flush;
  assign bus.idex_bubble     = idex_bubble;
  assign bus.exe_freeze      = exe_freeze;
  assign bus.memwb_bubble    = memwb_bubble;
  assign bus.stall_cycles    = stall_q;
  assign bus.flush_count     = flush_q;
  assign bus.mem_timeout_err = err_q;
endmodule
